// File: rtl/cache_pkg.sv
// Shared types and geometry for the two-way set-associative cache.
//   cache_state_t : controller states (IDLE, REFILL, WRITE)
//   DEF_*         : default geometry used by the top-level parameters
//   TAG_BITS/SETS/WORDS : geometry derived from the default parameters
//   calc_tag_bits : tag width from address/set/word field widths
package cache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } cache_state_t;

  localparam int DEF_ADDR_WIDTH = 32;
  localparam int DEF_SET_BITS   = 2;
  localparam int DEF_WORD_BITS  = 2;

  // Address = {tag, index, word offset, 2-bit byte offset}.
  function automatic int calc_tag_bits(input int aw, input int sb, input int wb);
    return aw - sb - wb - 2;
  endfunction

  localparam int TAG_BITS = calc_tag_bits(DEF_ADDR_WIDTH, DEF_SET_BITS, DEF_WORD_BITS);
  localparam int SETS     = 1 << DEF_SET_BITS;
  localparam int WORDS    = 1 << DEF_WORD_BITS;

endpackage

// File: rtl/cache_way.sv
// One way of the cache: valid bits, tags and line data.
//   lk_*     : combinational lookup (hit, word at lk_woff, valid of the set)
//   wr_*     : synchronous word write with per-byte enables
//   fill_*   : marks a set valid and records its tag
//   inv_all  : clears every valid bit
module cache_way
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_W      = TAG_BITS,
  parameter int N_SETS     = SETS,
  parameter int N_WORDS    = WORDS
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          inv_all,
  input  logic [$clog2(N_SETS)-1:0]     lk_idx,
  input  logic [TAG_W-1:0]              lk_tag,
  input  logic [$clog2(N_WORDS)-1:0]    lk_woff,
  output logic                          hit,
  output logic                          valid,
  output logic [DATA_WIDTH-1:0]         word,
  input  logic                          wr_en,
  input  logic [$clog2(N_SETS)-1:0]     wr_idx,
  input  logic [$clog2(N_WORDS)-1:0]    wr_woff,
  input  logic [DATA_WIDTH-1:0]         wr_data,
  input  logic [DATA_WIDTH/8-1:0]       wr_be,
  input  logic                          fill,
  input  logic [$clog2(N_SETS)-1:0]     fill_idx,
  input  logic [TAG_W-1:0]              fill_tag
);
  localparam int NB = DATA_WIDTH / 8;

  logic [N_SETS-1:0]     valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [N_SETS];
  logic [TAG_W-1:0]      tag_d  [N_SETS];
  logic [DATA_WIDTH-1:0] data_q [N_SETS*N_WORDS];
  logic [DATA_WIDTH-1:0] data_d [N_SETS*N_WORDS];

  assign valid = valid_q[lk_idx];
  assign hit   = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
  assign word  = data_q[{lk_idx, lk_woff}];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (wr_en) begin
      for (int b = 0; b < NB; b++) begin
        if (wr_be[b]) data_d[{wr_idx, wr_woff}][b*8 +: 8] = wr_data[b*8 +: 8];
      end
    end
    if (fill) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
    end
    if (inv_all) valid_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) valid_q <= '0;
    else        valid_q <= valid_d;
  end

  // Tags and data are only meaningful behind a valid bit, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/set_assoc_cache.sv
// Two-way set-associative write-through cache (no write-allocate, 1-bit LRU).
//   cpu_*   : load/store request side; hits complete combinationally
//   inv_all : invalidate all lines (taken only in IDLE)
//   mem_*   : req/ack memory port for line refills and store write-through
module set_assoc_cache
  import cache_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int SET_BITS   = DEF_SET_BITS,
  parameter int WORD_BITS  = DEF_WORD_BITS
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic                  cpu_we,
  input  logic                  cpu_byte,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_ready,
  input  logic                  inv_all,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic                  mem_byte,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_ack
);
  localparam int TAG_W   = calc_tag_bits(ADDR_WIDTH, SET_BITS, WORD_BITS);
  localparam int N_SETS  = 1 << SET_BITS;
  localparam int N_WORDS = 1 << WORD_BITS;
  localparam int IDX_LO  = WORD_BITS + 2;
  localparam int TAG_LO  = SET_BITS + WORD_BITS + 2;
  localparam int NB      = DATA_WIDTH / 8;

  logic [1:0]           off;
  logic [WORD_BITS-1:0] woff;
  logic [SET_BITS-1:0]  idx;
  logic [TAG_W-1:0]     tag;

  assign off  = cpu_addr[1:0];
  assign woff = cpu_addr[IDX_LO-1:2];
  assign idx  = cpu_addr[TAG_LO-1:IDX_LO];
  assign tag  = cpu_addr[ADDR_WIDTH-1:TAG_LO];

  cache_state_t         state_q, state_d;
  logic [WORD_BITS-1:0] cnt_q, cnt_d;
  logic [N_SETS-1:0]    lru_q, lru_d;     // per set: way to replace next
  logic                 victim_q, victim_d;
  logic [SET_BITS-1:0]  ridx_q, ridx_d;
  logic [TAG_W-1:0]     rtag_q, rtag_d;

  logic                 hit0, hit1, valid0, valid1;
  logic [DATA_WIDTH-1:0] word0, word1, hit_word;
  logic [7:0]           hit_byte;
  logic                 wr_en0, wr_en1, fill0, fill1, inv;
  logic [SET_BITS-1:0]  wr_idx;
  logic [WORD_BITS-1:0] wr_woff;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [NB-1:0]        wr_be;

  cache_way #(
    .DATA_WIDTH(DATA_WIDTH), .TAG_W(TAG_W), .N_SETS(N_SETS), .N_WORDS(N_WORDS)
  ) u_way0 (
    .clk(clk), .rst_n(rst_n), .inv_all(inv),
    .lk_idx(idx), .lk_tag(tag), .lk_woff(woff),
    .hit(hit0), .valid(valid0), .word(word0),
    .wr_en(wr_en0), .wr_idx(wr_idx), .wr_woff(wr_woff), .wr_data(wr_data), .wr_be(wr_be),
    .fill(fill0), .fill_idx(ridx_q), .fill_tag(rtag_q)
  );

  cache_way #(
    .DATA_WIDTH(DATA_WIDTH), .TAG_W(TAG_W), .N_SETS(N_SETS), .N_WORDS(N_WORDS)
  ) u_way1 (
    .clk(clk), .rst_n(rst_n), .inv_all(inv),
    .lk_idx(idx), .lk_tag(tag), .lk_woff(woff),
    .hit(hit1), .valid(valid1), .word(word1),
    .wr_en(wr_en1), .wr_idx(wr_idx), .wr_woff(wr_woff), .wr_data(wr_data), .wr_be(wr_be),
    .fill(fill1), .fill_idx(ridx_q), .fill_tag(rtag_q)
  );

  assign hit_word = hit1 ? word1 : word0;
  assign hit_byte = hit_word[{off, 3'b000} +: 8];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    lru_d     = lru_q;
    victim_d  = victim_q;
    ridx_d    = ridx_q;
    rtag_d    = rtag_q;
    cpu_ready = 1'b0;
    cpu_rdata = '0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_byte  = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    inv       = 1'b0;
    wr_en0    = 1'b0;
    wr_en1    = 1'b0;
    fill0     = 1'b0;
    fill1     = 1'b0;
    wr_idx    = idx;
    wr_woff   = woff;
    wr_data   = '0;
    wr_be     = '0;

    unique case (state_q)
      IDLE: begin
        if (inv_all) begin
          inv = 1'b1;
        end else if (cpu_req) begin
          if (cpu_we) begin
            state_d = WRITE;
          end else if (hit0 || hit1) begin
            cpu_ready  = 1'b1;
            cpu_rdata  = cpu_byte ? {{(DATA_WIDTH-8){1'b0}}, hit_byte} : hit_word;
            lru_d[idx] = hit0;
          end else begin
            state_d  = REFILL;
            cnt_d    = '0;
            // Fill empty ways first, lowest way wins; otherwise follow LRU.
            victim_d = !valid0 ? 1'b0 : (!valid1 ? 1'b1 : lru_q[idx]);
            ridx_d   = idx;
            rtag_d   = tag;
          end
        end
      end

      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {rtag_q, ridx_q, cnt_q, 2'b00};
        if (mem_ack) begin
          wr_en0  = !victim_q;
          wr_en1  = victim_q;
          wr_idx  = ridx_q;
          wr_woff = cnt_q;
          wr_data = mem_rdata;
          wr_be   = '1;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == WORD_BITS'(N_WORDS - 1)) begin
            fill0         = !victim_q;
            fill1         = victim_q;
            lru_d[ridx_q] = !victim_q;
            state_d       = IDLE;
          end
        end
      end

      WRITE: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_byte  = cpu_byte;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        if (mem_ack) begin
          cpu_ready = 1'b1;
          state_d   = IDLE;
          // Write-through without allocate: only a resident line is updated.
          if (hit0 || hit1) begin
            wr_en0 = hit0;
            wr_en1 = hit1;
            if (cpu_byte) begin
              wr_data      = {NB{cpu_wdata[7:0]}};
              wr_be[off]   = 1'b1;
            end else begin
              wr_data = cpu_wdata;
              wr_be   = '1;
            end
            lru_d[idx] = hit0;
          end
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      lru_q    <= '0;
      victim_q <= 1'b0;
      ridx_q   <= '0;
      rtag_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      lru_q    <= lru_d;
      victim_q <= victim_d;
      ridx_q   <= ridx_d;
      rtag_q   <= rtag_d;
    end
  end

endmodule

// File: tb/tb_set_assoc_cache.sv
// Scoreboard bench for set_assoc_cache: the driver pushes the expected
// load data and refill count; a negedge monitor pops on cpu_ready.
// Reference: flat memory array plus a per-set recency list of resident tags.
module tb_set_assoc_cache;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0, cpu_byte = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic [31:0] cpu_rdata;
  logic        cpu_ready;
  logic        inv_all = 1'b0;
  logic        mem_req, mem_we, mem_byte;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;

  always #5 clk = ~clk;

  set_assoc_cache dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_byte(cpu_byte),
    .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .inv_all(inv_all),
    .mem_req(mem_req), .mem_we(mem_we), .mem_byte(mem_byte),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
  endtask

  typedef struct {
    bit          we;
    logic [31:0] data;
    int          reads;
  } exp_t;
  exp_t sb_q[$];

  // ---------------- reference model ----------------
  logic [31:0] mem_a [logic [31:0]];
  int unsigned tagq [4][$];   // front = most recently used

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    logic [31:0] k;
    k = {a[31:2], 2'b00};
    if (mem_a.exists(k)) return mem_a[k];
    return (k * 32'h9E3779B1) ^ 32'h13572468;
  endfunction

  function automatic bit model_touch(input logic [31:0] a, input bit alloc);
    int unsigned t;
    int s;
    t = a >> 6;
    s = int'((a >> 4) & 32'h3);
    for (int i = 0; i < tagq[s].size(); i++) begin
      if (tagq[s][i] == t) begin
        tagq[s].delete(i);
        tagq[s].push_front(t);
        return 1'b1;
      end
    end
    if (alloc) begin
      tagq[s].push_front(t);
      if (tagq[s].size() > 2) void'(tagq[s].pop_back());
    end
    return 1'b0;
  endfunction

  task automatic model_clear();
    for (int s = 0; s < 4; s++) tagq[s].delete();
  endtask

  // ---------------- memory responder ----------------
  logic        cur_we = 1'b0, cur_byte = 1'b0;
  logic [31:0] cur_addr = '0, cur_wdata = '0;

  always @(posedge clk) begin
    #2;
    mem_ack   = 1'b0;
    mem_rdata = $urandom;
    if (rst_n && mem_req && ($urandom_range(0, 2) != 0)) begin
      mem_ack = 1'b1;
      check("mem_we", 32'(mem_we), 32'(cur_we));
      if (mem_we) begin
        check("mem_addr_wr", mem_addr, cur_addr);
        check("mem_byte", 32'(mem_byte), 32'(cur_byte));
        check("mem_wdata", mem_wdata, cur_wdata);
      end else begin
        check("mem_line", 32'(mem_addr[31:4]), 32'(cur_addr[31:4]));
        mem_rdata = mem_rd(mem_addr);
      end
    end
  end

  // ---------------- monitor ----------------
  int rd_cnt = 0;
  int wait_cnt = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      rd_cnt   = 0;
      wait_cnt = 0;
    end else begin
      if (mem_req && mem_ack && !mem_we) rd_cnt++;
      if (cpu_ready) begin
        if (sb_q.size() == 0) begin
          n_total++;
          $display("FAIL unexpected_ready: rdata 0x%08h with empty scoreboard", cpu_rdata);
        end else begin
          e = sb_q.pop_front();
          check("cpu_rdata", cpu_rdata, e.data);
          check("refill_acks", 32'(rd_cnt), 32'(e.reads));
          if (!e.we && e.reads == 0) check("hit_latency", 32'(wait_cnt), 32'd0);
        end
        rd_cnt   = 0;
        wait_cnt = 0;
      end else begin
        check("rdata_not_ready", cpu_rdata, 32'd0);
        if (cpu_req) wait_cnt++;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic access(input bit we, input bit bt, input logic [31:0] addr,
                        input logic [31:0] wd);
    exp_t e;
    bit hit;
    bit done;
    logic [31:0] w;
    @(posedge clk); #1;
    w = mem_rd(addr);
    e.we = we;
    if (!we) begin
      hit     = model_touch(addr, 1'b1);
      e.data  = bt ? ((w >> (int'(addr[1:0]) * 8)) & 32'hFF) : w;
      e.reads = hit ? 0 : 4;
    end else begin
      void'(model_touch(addr, 1'b0));
      if (bt) w[int'(addr[1:0])*8 +: 8] = wd[7:0];
      else    w = wd;
      mem_a[{addr[31:2], 2'b00}] = w;
      e.data  = '0;
      e.reads = 0;
    end
    sb_q.push_back(e);
    cur_we = we; cur_byte = bt; cur_addr = addr; cur_wdata = wd;
    cpu_we = we; cpu_byte = bt; cpu_addr = addr; cpu_wdata = wd;
    cpu_req = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cpu_ready) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      n_total++;
      $display("FAIL access_timeout: addr 0x%08h we %0d got no cpu_ready, expected one within 200 cycles", addr, we);
      sb_q.delete();
    end
    @(posedge clk); #1;
    cpu_req = 1'b0;
  endtask

  task automatic do_inv();
    @(posedge clk); #1;
    inv_all = 1'b1;
    @(negedge clk);
    check("inv_ready", 32'(cpu_ready), 32'd0);
    @(posedge clk); #1;
    inv_all = 1'b0;
    model_clear();
  endtask

  initial begin
    int acks;
    logic [31:0] a;
    bit we, bt;
    int r;

    mem_a[32'h40] = 32'h0000_0011;
    mem_a[32'h44] = 32'h0000_0022;
    mem_a[32'h48] = 32'h0000_0033;
    mem_a[32'h4C] = 32'hAABB_CCDD;

    // Outputs during reset, with a store request pending.
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h40; cpu_wdata = 32'hFFFF_FFFF;
    repeat (2) @(negedge clk);
    check("rst_cpu_ready", 32'(cpu_ready), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_byte", 32'(mem_byte), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_mem_wdata", mem_wdata, 32'd0);
    cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Miss + refill, hit, byte load.
    access(1'b0, 1'b0, 32'h40, 32'h0);
    access(1'b0, 1'b0, 32'h48, 32'h0);
    access(1'b0, 1'b1, 32'h4D, 32'h0);
    // Byte store hit, readback, store miss.
    access(1'b1, 1'b1, 32'h41, 32'h1234_56EE);
    access(1'b0, 1'b0, 32'h40, 32'h0);
    access(1'b1, 1'b0, 32'h200, 32'h1234_5678);
    access(1'b0, 1'b0, 32'h200, 32'h0);

    // Set 0 replacement: A, B, A, C (evicts B), A hits, B misses.
    do_inv();
    access(1'b0, 1'b0, 32'h000, 32'h0);
    access(1'b0, 1'b0, 32'h040, 32'h0);
    access(1'b0, 1'b0, 32'h000, 32'h0);
    access(1'b0, 1'b0, 32'h080, 32'h0);
    access(1'b0, 1'b0, 32'h004, 32'h0);
    access(1'b0, 1'b0, 32'h044, 32'h0);

    // Invalidate after a fill.
    do_inv();
    access(1'b0, 1'b0, 32'h40, 32'h0);
    access(1'b0, 1'b0, 32'h40, 32'h0);

    // Reset after two of four refill acks.
    do_inv();
    @(posedge clk); #1;
    cur_we = 1'b0; cur_byte = 1'b0; cur_addr = 32'h40; cur_wdata = '0;
    cpu_we = 1'b0; cpu_byte = 1'b0; cpu_addr = 32'h40;
    cpu_req = 1'b1;
    acks = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (mem_req && mem_ack && !mem_we) acks++;
      if (acks == 2) break;
    end
    check("partial_refill_acks", 32'(acks), 32'd2);
    @(posedge clk); #1;
    rst_n = 1'b0;
    cpu_req = 1'b0;
    #1;
    check("rst_mid_mem_req", 32'(mem_req), 32'd0);
    check("rst_mid_cpu_ready", 32'(cpu_ready), 32'd0);
    model_clear();
    @(posedge clk); #1;
    rst_n = 1'b1;
    access(1'b0, 1'b0, 32'h40, 32'h0);

    // Randomized traffic over a small, conflict-heavy address range.
    for (int n = 0; n < 400; n++) begin
      r = int'($urandom_range(0, 19));
      if (r == 0) begin
        do_inv();
      end else begin
        we = (r < 7);
        bt = 1'($urandom_range(0, 1));
        a  = 32'($urandom_range(0, 32'h3FF));
        if (!bt) a[1:0] = 2'b00;
        access(we, bt, a, $urandom);
      end
    end

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
